// File: rtl/latch_down_counter_pkg.sv
// rtl/latch_down_counter_pkg.sv - shared types and helpers for the latch_down_counter block
// Next-state selection for the non-reset path, in priority order load > dec > hold.
package latch_down_counter_pkg;

  localparam int LDC_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_DEC  = 2'd1,
    SEL_LOAD = 2'd2
  } ldc_sel_e;

  // A decrement request at zero collapses to hold, which is what gives saturation.
  function automatic ldc_sel_e ldc_next_sel(
    input logic latch,
    input logic dec,
    input logic at_zero
  );
    if (latch)                 return SEL_LOAD;
    else if (dec && !at_zero)  return SEL_DEC;
    else                       return SEL_HOLD;
  endfunction

endpackage

// File: rtl/latch_down_counter.sv
// rtl/latch_down_counter.sv - loadable saturating down-counter with a zero flag
// Reset beats latch beats dec beats hold on every rising edge of clock.
module latch_down_counter
  import latch_down_counter_pkg::*;
#(
  parameter int WIDTH = LDC_DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             latch,
  input  logic             dec,
  output logic             zero,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             w_at_zero;
  ldc_sel_e         w_sel;

  assign w_at_zero = (r_count == '0);

  always_comb begin
    w_next = r_count;
    w_sel  = ldc_next_sel(latch, dec, w_at_zero);
    case (w_sel)
      SEL_LOAD: w_next = in;
      SEL_DEC:  w_next = r_count - 1'b1;
      default:  w_next = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign count = r_count;
  assign zero  = w_at_zero;

  a_zero_decode: assert property (@(posedge clock) zero == (count == '0));

  a_no_underflow: assert property (@(posedge clock)
    (!reset && count == '0 && dec && !latch) |=> (count == '0));

  a_load: assert property (@(posedge clock)
    (!reset && latch) |=> (count == $past(in)));

endmodule

// File: tb/tb_latch_down_counter.sv
// tb/tb_latch_down_counter.sv - directed self-checking bench for latch_down_counter
// Inputs change #1 after each rising edge; outputs are checked at that same point.
module tb_latch_down_counter;

  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic [W-1:0] in;
  logic         latch;
  logic         dec;
  logic         zero;
  logic [W-1:0] count;

  int n_checks;
  int n_fail;

  latch_down_counter #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .latch (latch),
    .dec   (dec),
    .zero  (zero),
    .count (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] exp_count, input logic exp_zero);
    n_checks++;
    assert (count === exp_count) else begin
      n_fail++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, count, exp_count);
    end
    n_checks++;
    assert (zero === exp_zero) else begin
      n_fail++;
      $error("FAIL %s zero observed=%0b expected=%0b", tag, zero, exp_zero);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    latch = 1'b0;
    dec   = 1'b0;
    in    = '0;

    // Reset for two edges, then idle hold.
    edge_step();
    edge_step();
    chk("reset", 4'd0, 1'b1);
    reset = 1'b0;
    edge_step();
    edge_step();
    chk("reset_idle", 4'd0, 1'b1);

    // Load 5, then count down to 0.
    in = 4'd5; latch = 1'b1;
    edge_step();
    chk("load5", 4'd5, 1'b0);
    latch = 1'b0; dec = 1'b1; in = 4'd12;
    for (int e = 4; e >= 0; e--) begin
      edge_step();
      chk($sformatf("down_%0d", e), W'(e), (e == 0));
    end

    // Saturation at zero.
    for (int k = 0; k < 5; k++) begin
      edge_step();
      chk($sformatf("sat_%0d", k), 4'd0, 1'b1);
    end

    // Load overrides dec.
    in = 4'd3; latch = 1'b1;
    edge_step();
    chk("load3", 4'd3, 1'b0);
    in = 4'd9;
    edge_step();
    chk("load_over_dec", 4'd9, 1'b0);

    // Latch held high reloads every edge with no decrement.
    in = 4'd10;
    edge_step();
    chk("reload10", 4'd10, 1'b0);
    in = 4'd11;
    edge_step();
    chk("reload11", 4'd11, 1'b0);

    // Hold at 7 while in wiggles with latch low.
    in = 4'd7; dec = 1'b0;
    edge_step();
    chk("load7", 4'd7, 1'b0);
    latch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in = W'(k + 1);
      edge_step();
      chk($sformatf("hold_%0d", k), 4'd7, 1'b0);
    end
    in = 4'd0; latch = 1'b1;
    edge_step();
    chk("load0", 4'd0, 1'b1);

    // Reset mid-count wins over latch and dec.
    in = 4'd6;
    edge_step();
    chk("load6", 4'd6, 1'b0);
    latch = 1'b0; dec = 1'b1;
    edge_step();
    chk("dec6", 4'd5, 1'b0);
    reset = 1'b1; latch = 1'b1; in = 4'd15;
    edge_step();
    chk("reset_wins", 4'd0, 1'b1);
    reset = 1'b0; latch = 1'b0;
    edge_step();
    chk("post_reset_sat", 4'd0, 1'b1);

    // Load 1 with dec high reaches zero after exactly one edge.
    in = 4'd1; latch = 1'b1;
    edge_step();
    chk("load1", 4'd1, 1'b0);
    latch = 1'b0;
    edge_step();
    chk("load1_zero", 4'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
